// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped UART transmitter. The CPU stores bytes through the MemOrIO
// decoder. The block queues them in a small FIFO and sends each one as a
// serial frame: one start bit, 8 data bits LSB first, then one stop bit.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. This makes each frame 11 bit times
// long. With the macro undefined the frame is plain 8N1, 10 bit times long.
//
// Parameters
//   CLK_HZ      clock frequency in Hz
//   BAUD        line rate. One bit lasts DIV = CLK_HZ/BAUD cycles. DIV >= 4.
//   FIFO_DEPTH  byte FIFO depth, a power of two from 2 to 256
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   uartcs         chip select
//   uartwrite      write strobe. addr 0 pushes a byte, addr 1 clears overflow.
//   uartread       read strobe. Any address returns the status word.
//   uartaddr       word offset
//   uartinputdata  byte to push
//   uartreaddata   status: {5'b0, count[7:0], overflow, idle, full}.
//                  It is 0 when no read is active.
//   tx             serial output, idle high, driven from a register
//   busy           high while bytes are queued or a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter int CLK_HZ     = 23_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [7:0]  uartinputdata,
    output logic [15:0] uartreaddata,
    output logic        tx,
    output logic        busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BAUD_LAST  = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Register interface decode
    // ------------------------------------------------------------------
    logic push_req;
    logic clr_req;
    logic push_ok;
    logic pop;

    assign push_req = uartcs & uartwrite & (uartaddr == 2'd0);
    assign clr_req  = uartcs & uartwrite & (uartaddr == 2'd1);

    // ------------------------------------------------------------------
    // Byte FIFO. The storage array has no reset so it can map onto RAM.
    // It is read only by the pop that loads the shift register.
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;
    logic          overflow_reg;
    logic          overflow_next;
    logic          fifo_full;
    logic          fifo_empty;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign fifo_empty = (count_reg == '0);
    // A full FIFO drops the byte, even if a pop happens on the same edge.
    assign push_ok    = push_req & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= uartinputdata;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        overflow_next = overflow_reg;
        if (clr_req) begin
            overflow_next = 1'b0;
        end
        if (push_req && fifo_full) begin
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] baud_cnt_reg;
    logic [CW-1:0] baud_cnt_next;
    logic [2:0]    bit_cnt_reg;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          tx_reg;
    logic          tx_next;
    logic          bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_reg;
    logic parity_next;
`endif

    assign bit_end = (baud_cnt_reg == BAUD_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt_reg == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // If another byte is queued, go straight to its start bit.
                // This avoids an idle gap between back-to-back frames.
                if (bit_end) begin
                    state_next = fifo_empty ? ST_IDLE : ST_START;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and datapath logic.
    // tx_next is taken from the state being entered. This way the
    // registered tx changes on the same edge as the state does.
    always_comb begin
        pop           = 1'b0;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        baud_cnt_next = '0;
        if ((state_reg != ST_IDLE) && !bit_end) begin
            baud_cnt_next = baud_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end && !fifo_empty) begin
                    pop          = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            default: ;
        endcase

        if (pop) begin
            shift_next = fifo_mem[rd_ptr_reg];
        end

`ifdef UART_TX_PARITY_EN
        // Capture parity at load time, because the shift register
        // no longer holds the whole byte by the parity slot.
        parity_next = pop ? ^shift_next : parity_reg;
`endif

        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_reg;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx   = tx_reg;
    assign busy = ~fifo_empty | (state_reg != ST_IDLE);

    always_comb begin
        uartreaddata = '0;
        if (uartcs && uartread) begin
            uartreaddata = {5'b0, 8'(count_reg), overflow_reg, ~busy, fifo_full};
        end
    end

endmodule
